// File: rtl/prog_clk_divider.sv
// prog_clk_divider: runtime-programmable integer clock divider.
// Divides clk by N (2..2^WIDTH-1), emits a near-50% duty clk_out, a one-cycle
// tick at the start of every output period and NTAPS binary sub-divided taps.
// Ratio changes are queued and applied only at a period boundary.
// Optional macro DUTY50_ODD_EN: for odd N, a negedge register stretches the
// high phase by half a clk period to give exactly 50% duty.
module prog_clk_divider #(
  parameter int WIDTH = 8,
  parameter int NTAPS = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] ratio,
  input  logic             ratio_load,
  output logic             ratio_ack,
  output logic             ratio_err,
  output logic             clk_out,
  output logic             tick,
  output logic [NTAPS-1:0] taps
);

  localparam logic [WIDTH-1:0] RESET_RATIO = WIDTH'(2);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_next;
  logic [WIDTH-1:0] act_ratio;
  logic [WIDTH-1:0] pend;
  logic             pend_valid;
  logic [WIDTH-1:0] n_next;
  logic [WIDTH:0]   half;
  logic [NTAPS-1:0] tap_cnt;
  logic             hi_q;
  logic             hi_next;
  logic             wrap;
  logic             swap;
  logic             load_ok;
  logic             load_bad;

`ifdef DUTY50_ODD_EN
  logic odd_q;
  logic neg_hi;
`endif

  // Next-state decode: period wrap, ratio swap and the next clk_out level.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wrap     = 1'b0;
    swap     = 1'b0;
    load_ok  = 1'b0;
    load_bad = 1'b0;
    n_next   = act_ratio;
    cnt_next = cnt + WIDTH'(1);
    half     = '0;
    hi_next  = 1'b0;

    wrap     = en && (cnt == act_ratio - WIDTH'(1));
    swap     = wrap && pend_valid;
    load_ok  = ratio_load && (ratio >= RESET_RATIO);
    load_bad = ratio_load && (ratio <  RESET_RATIO);

    // The ratio that takes effect at a wrap governs that edge's clk_out value.
    if (swap)
      n_next = pend;
    if (wrap)
      cnt_next = '0;

`ifdef DUTY50_ODD_EN
    // floor(N/2): exact half for even N; odd N gets the extra half cycle from neg_hi.
    half = {1'b0, n_next} >> 1;
`else
    // ceil(N/2): odd N stays high one clk longer than low.
    half = ({1'b0, n_next} + (WIDTH+1)'(1)) >> 1;
`endif
    hi_next = ({1'b0, cnt_next} < half);
  end

  // Period counter, ratio registers, tap counter and registered pulse outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      act_ratio  <= RESET_RATIO;
      pend       <= RESET_RATIO;
      pend_valid <= 1'b0;
      tap_cnt    <= '0;
      hi_q       <= 1'b0;
      tick       <= 1'b0;
      ratio_ack  <= 1'b0;
      ratio_err  <= 1'b0;
`ifdef DUTY50_ODD_EN
      odd_q      <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      tick      <= wrap;
      ratio_ack <= swap;
      ratio_err <= load_bad;

      if (en) begin
        cnt  <= cnt_next;
        hi_q <= hi_next;
`ifdef DUTY50_ODD_EN
        odd_q <= n_next[0];
`endif
      end

      if (swap)
        act_ratio <= pend;

      if (wrap)
        tap_cnt <= tap_cnt + NTAPS'(1);

      // A load on a swap edge is captured after the old pending value moves to active.
      if (load_ok) begin
        pend       <= ratio;
        pend_valid <= 1'b1;
      end else if (swap) begin
        pend_valid <= 1'b0;
      end
    end
  end

`ifdef DUTY50_ODD_EN
  // Half-cycle stretch of the high phase, only while the active ratio is odd.
  always_ff @(negedge clk or posedge rst) begin
    if (rst)
      neg_hi <= 1'b0;
    else
      neg_hi <= hi_q & odd_q;
  end

  assign clk_out = hi_q | neg_hi;
`else
  assign clk_out = hi_q;
`endif

  assign taps = tap_cnt;

endmodule

// File: tb/tb_prog_clk_divider.sv
// tb_prog_clk_divider: directed self-checking bench for prog_clk_divider.
// Inputs change 1 ns after a posedge; outputs are sampled at that same point.
module tb_prog_clk_divider;

  localparam int WIDTH = 8;
  localparam int NTAPS = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [WIDTH-1:0] ratio;
  logic             ratio_load;
  logic             ratio_ack;
  logic             ratio_err;
  logic             clk_out;
  logic             tick;
  logic [NTAPS-1:0] taps;

  int n_compared   = 0;
  int n_mismatched = 0;

  prog_clk_divider #(.WIDTH(WIDTH), .NTAPS(NTAPS)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .ratio      (ratio),
    .ratio_load (ratio_load),
    .ratio_ack  (ratio_ack),
    .ratio_err  (ratio_err),
    .clk_out    (clk_out),
    .tick       (tick),
    .taps       (taps)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold reset for two edges, release it just after a posedge and enable counting.
  task automatic do_reset();
    rst        = 1'b1;
    en         = 1'b0;
    ratio_load = 1'b0;
    ratio      = '0;
    step();
    step();
    rst = 1'b0;
    en  = 1'b1;
  endtask

  task automatic test_reset();
    logic [4:0] got;
    rst        = 1'b0;
    en         = 1'b0;
    ratio_load = 1'b0;
    ratio      = '0;
    #1 rst = 1'b1;
    #2;
    got = {clk_out, tick, ratio_ack, ratio_err, |taps};
    n_compared++;
    if (got !== 5'b00000) begin
      $display("FAIL reset_outputs: got %b expected 00000 (clk_out,tick,ack,err,taps)", got);
      n_mismatched++;
    end
    n_compared++;
    if (taps !== 3'b000) begin
      $display("FAIL reset_taps: got %b expected 000", taps);
      n_mismatched++;
    end
  endtask

  // N=2 after reset: clk_out toggles every clk, taps[0] period 4, taps[2] period 16.
  task automatic test_div2();
    logic [15:0] v_clk, v_tick, v_t0, v_t2;
    do_reset();
    v_clk = '0; v_tick = '0; v_t0 = '0; v_t2 = '0;
    for (int i = 0; i < 16; i++) begin
      step();
      v_clk  = {v_clk[14:0],  clk_out};
      v_tick = {v_tick[14:0], tick};
      v_t0   = {v_t0[14:0],   taps[0]};
      v_t2   = {v_t2[14:0],   taps[2]};
    end
    n_compared++;
    if (v_clk !== 16'h5555) begin
      $display("FAIL div2_clk_out: got %h expected 5555", v_clk); n_mismatched++;
    end
    n_compared++;
    if (v_tick !== 16'h5555) begin
      $display("FAIL div2_tick: got %h expected 5555", v_tick); n_mismatched++;
    end
    n_compared++;
    if (v_t0 !== 16'h6666) begin
      $display("FAIL div2_taps0: got %h expected 6666", v_t0); n_mismatched++;
    end
    n_compared++;
    if (v_t2 !== 16'h01fe) begin
      $display("FAIL div2_taps2: got %h expected 01fe", v_t2); n_mismatched++;
    end
  endtask

  // Load 6 on a non-wrap edge; ack at the next wrap, then 3 high / 3 low.
  task automatic test_ratio6();
    logic [13:0] v_clk, v_tick, v_ack;
    do_reset();
    v_clk = '0; v_tick = '0; v_ack = '0;
    for (int i = 0; i < 14; i++) begin
      ratio_load = (i == 0);
      ratio      = 8'd6;
      step();
      ratio_load = 1'b0;
      v_clk  = {v_clk[12:0],  clk_out};
      v_tick = {v_tick[12:0], tick};
      v_ack  = {v_ack[12:0],  ratio_ack};
    end
    n_compared++;
    if (v_clk !== 14'b01110001110001) begin
      $display("FAIL ratio6_clk_out: got %b expected 01110001110001", v_clk); n_mismatched++;
    end
    n_compared++;
    if (v_tick !== 14'b01000001000001) begin
      $display("FAIL ratio6_tick: got %b expected 01000001000001", v_tick); n_mismatched++;
    end
    n_compared++;
    if (v_ack !== 14'b01000000000000) begin
      $display("FAIL ratio6_ack: got %b expected 01000000000000", v_ack); n_mismatched++;
    end
  endtask

  // Odd ratio 5: 3 high / 2 low by default; 2.5 high with the duty option.
  task automatic test_ratio5();
    logic [11:0] v_clk, v_tick;
    logic        mid_sample;
    logic        mid_expect;
`ifdef DUTY50_ODD_EN
    mid_expect = 1'b0;
`else
    mid_expect = 1'b1;
`endif
    do_reset();
    v_clk = '0; v_tick = '0; mid_sample = 1'bx;
    for (int i = 0; i < 12; i++) begin
      ratio_load = (i == 0);
      ratio      = 8'd5;
      step();
      ratio_load = 1'b0;
      v_clk  = {v_clk[10:0],  clk_out};
      v_tick = {v_tick[10:0], tick};
      if (i == 3) begin
        @(negedge clk);
        #1;
        mid_sample = clk_out;
      end
    end
    n_compared++;
    if (v_clk !== 12'b011100111001) begin
      $display("FAIL ratio5_clk_out: got %b expected 011100111001", v_clk); n_mismatched++;
    end
    n_compared++;
    if (v_tick !== 12'b010000100001) begin
      $display("FAIL ratio5_tick: got %b expected 010000100001", v_tick); n_mismatched++;
    end
    n_compared++;
    if (mid_sample !== mid_expect) begin
      $display("FAIL ratio5_third_half_cycle: got %b expected %b", mid_sample, mid_expect);
      n_mismatched++;
    end
  endtask

  // Ratios 1 and 0 are rejected: two error pulses, no ack, N stays 2.
  task automatic test_ratio_err();
    logic [7:0] v_clk, v_err, v_ack;
    do_reset();
    v_clk = '0; v_err = '0; v_ack = '0;
    for (int i = 0; i < 8; i++) begin
      ratio_load = (i == 0) || (i == 2);
      ratio      = (i == 0) ? 8'd1 : 8'd0;
      step();
      ratio_load = 1'b0;
      v_clk = {v_clk[6:0], clk_out};
      v_err = {v_err[6:0], ratio_err};
      v_ack = {v_ack[6:0], ratio_ack};
    end
    n_compared++;
    if (v_err !== 8'b10100000) begin
      $display("FAIL err_pulses: got %b expected 10100000", v_err); n_mismatched++;
    end
    n_compared++;
    if (v_ack !== 8'b00000000) begin
      $display("FAIL err_no_ack: got %b expected 00000000", v_ack); n_mismatched++;
    end
    n_compared++;
    if (v_clk !== 8'b01010101) begin
      $display("FAIL err_ratio_kept: got %b expected 01010101", v_clk); n_mismatched++;
    end
  endtask

  // N=6, then loads 4 and 9 before the wrap, then 3 on the wrap edge that swaps in 9.
  task automatic test_back_to_back();
    logic [21:0] v_clk, v_tick, v_ack;
    do_reset();
    v_clk = '0; v_tick = '0; v_ack = '0;
    for (int i = 0; i < 22; i++) begin
      ratio_load = (i == 0) || (i == 2) || (i == 4) || (i == 7);
      case (i)
        0:       ratio = 8'd6;
        2:       ratio = 8'd4;
        4:       ratio = 8'd9;
        default: ratio = 8'd3;
      endcase
      step();
      ratio_load = 1'b0;
      v_clk  = {v_clk[20:0],  clk_out};
      v_tick = {v_tick[20:0], tick};
      v_ack  = {v_ack[20:0],  ratio_ack};
    end
    n_compared++;
    if (v_clk !== 22'b0111000111110000110110) begin
      $display("FAIL b2b_clk_out: got %b expected 0111000111110000110110", v_clk); n_mismatched++;
    end
    n_compared++;
    if (v_tick !== 22'b0100000100000000100100) begin
      $display("FAIL b2b_tick: got %b expected 0100000100000000100100", v_tick); n_mismatched++;
    end
    n_compared++;
    if (v_ack !== 22'b0100000100000000100000) begin
      $display("FAIL b2b_ack: got %b expected 0100000100000000100000", v_ack); n_mismatched++;
    end
    n_compared++;
    if (taps !== 3'd4) begin
      $display("FAIL b2b_taps: got %0d expected 4", taps); n_mismatched++;
    end
  endtask

  // N=6, en low for 7 edges mid-period: everything freezes, a load error still pulses.
  task automatic test_enable_hold();
    logic [16:0]      v_clk, v_tick, v_err;
    logic [NTAPS-1:0] taps_frozen;
    do_reset();
    v_clk = '0; v_tick = '0; v_err = '0; taps_frozen = 'x;
    for (int i = 0; i < 17; i++) begin
      en         = !(i >= 4 && i < 11);
      ratio_load = (i == 0) || (i == 6);
      ratio      = (i == 0) ? 8'd6 : 8'd0;
      step();
      ratio_load = 1'b0;
      v_clk  = {v_clk[15:0],  clk_out};
      v_tick = {v_tick[15:0], tick};
      v_err  = {v_err[15:0],  ratio_err};
      if (i == 10)
        taps_frozen = taps;
    end
    en = 1'b1;
    n_compared++;
    if (v_clk !== 17'b01111111111000111) begin
      $display("FAIL hold_clk_out: got %b expected 01111111111000111", v_clk); n_mismatched++;
    end
    n_compared++;
    if (v_tick !== 17'b01000000000000100) begin
      $display("FAIL hold_tick: got %b expected 01000000000000100", v_tick); n_mismatched++;
    end
    n_compared++;
    if (v_err !== 17'b00000010000000000) begin
      $display("FAIL hold_err: got %b expected 00000010000000000", v_err); n_mismatched++;
    end
    n_compared++;
    if (taps_frozen !== 3'd1) begin
      $display("FAIL hold_taps_frozen: got %0d expected 1", taps_frozen); n_mismatched++;
    end
    n_compared++;
    if (taps !== 3'd2) begin
      $display("FAIL hold_taps_resume: got %0d expected 2", taps); n_mismatched++;
    end
  endtask

  // Reset asserted mid-period at N=9 with 5 pending: outputs clear at once, N reverts to 2.
  task automatic test_reset_mid();
    logic [3:0] v_clk, v_ack;
    logic [3:0] got;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      ratio_load = (i == 0) || (i == 2);
      ratio      = (i == 0) ? 8'd9 : 8'd5;
      step();
      ratio_load = 1'b0;
    end
    n_compared++;
    if (clk_out !== 1'b1 || taps !== 3'd1) begin
      $display("FAIL rstmid_before: got clk_out=%b taps=%0d expected clk_out=1 taps=1", clk_out, taps);
      n_mismatched++;
    end
    #2 rst = 1'b1;
    #1;
    got = {clk_out, tick, ratio_ack, ratio_err};
    n_compared++;
    if (got !== 4'b0000 || taps !== 3'd0) begin
      $display("FAIL rstmid_async_clear: got %b taps=%0d expected 0000 taps=0", got, taps);
      n_mismatched++;
    end
    step();
    rst = 1'b0;
    en  = 1'b1;
    v_clk = '0; v_ack = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      v_clk = {v_clk[2:0], clk_out};
      v_ack = {v_ack[2:0], ratio_ack};
    end
    n_compared++;
    if (v_clk !== 4'b0101) begin
      $display("FAIL rstmid_ratio2: got %b expected 0101", v_clk); n_mismatched++;
    end
    n_compared++;
    if (v_ack !== 4'b0000) begin
      $display("FAIL rstmid_pend_dropped: got %b expected 0000", v_ack); n_mismatched++;
    end
  endtask

  initial begin
    test_reset();
    test_div2();
    test_ratio6();
    test_ratio5();
    test_ratio_err();
    test_back_to_back();
    test_enable_hold();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
